// File: rtl/mygo_chan_pkg.sv
// rtl/mygo_chan_pkg.sv - shared helpers and types for the parametrised channel FIFO
package mygo_chan_pkg;

    typedef enum logic {
        OPEN   = 1'b0,
        CLOSED = 1'b1
    } chan_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Occupancy must represent 0..DEPTH inclusive.
    function automatic int count_width(input int depth);
        return (clog2(depth + 1) < 1) ? 1 : clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mygo_chan_ptr.sv
// rtl/mygo_chan_ptr.sv - wrap-around buffer pointer with increment enable
module mygo_chan_ptr
    import mygo_chan_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PW    = ptr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    // Explicit compare so non-power-of-two depths wrap correctly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/mygo_chan_fifo.sv
// rtl/mygo_chan_fifo.sv - parametrised channel FIFO with close/drain semantics and optional bypass
module mygo_chan_fifo
    import mygo_chan_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int DEPTH    = 8,
    parameter  bit BYPASS   = 1'b0,
    parameter  int AFULL_TH = DEPTH - 1,
    localparam int CW       = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             close_req,
    output logic             closed,
    output logic             drained,
    output logic             err_send_closed,
    output logic [CW-1:0]    count,
    output logic             almost_full
);

    localparam int          PW      = ptr_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    chan_state_e      state;
    chan_state_e      state_next;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             wr_en;
    logic             rd_en;

    assign full   = (count == DEPTH_C);
    assign empty  = (count == '0);
    assign closed = (state == CLOSED);

    // Gated by rst so the producer sees backpressure while reset is held.
    assign in_ready  = rst && !full && !closed;
    assign push      = in_valid && in_ready;
    assign out_valid = !empty || (BYPASS && push);
    assign out_data  = (BYPASS && empty) ? in_data : mem[rd_ptr];
    assign pop       = out_valid && out_ready;

    // A bypassed element taken in the same cycle never touches storage.
    assign wr_en = push && !(pop && empty);
    assign rd_en = pop && !empty;

    assign drained     = closed && empty;
    assign almost_full = (count >= AFULL_C);

    mygo_chan_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_en),
        .ptr (wr_ptr)
    );

    mygo_chan_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_en),
        .ptr (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= OPEN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (close_req) begin
            state_next = CLOSED;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_send_closed <= 1'b0;
        end else if (in_valid && closed) begin
            err_send_closed <= 1'b1;
        end
    end

endmodule
